// File: rtl/mpsoc_msi_slave_port_qos.sv
// QoS slave-port arbiter for a multi-master AHB-Lite interconnect: picks the master
// with the highest effective priority, round-robin within a level, and ages losers toward the top level.
module mpsoc_msi_slave_port_qos #(
  parameter int PLEN         = 64,
  parameter int XLEN         = 64,
  parameter int MASTERS      = 5,
  parameter int PRIO_BITS    = 3,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                                HCLK,
  input  logic                                HRESETn,

  input  logic [MASTERS-1:0][PRIO_BITS-1:0]   mstpriority,
  input  logic [MASTERS-1:0]                  mstHSEL,
  input  logic [MASTERS-1:0][PLEN-1:0]        mstHADDR,
  input  logic [MASTERS-1:0][XLEN-1:0]        mstHWDATA,
  input  logic [MASTERS-1:0]                  mstHWRITE,
  input  logic [MASTERS-1:0][2:0]             mstHSIZE,
  input  logic [MASTERS-1:0][2:0]             mstHBURST,
  input  logic [MASTERS-1:0][3:0]             mstHPROT,
  input  logic [MASTERS-1:0][1:0]             mstHTRANS,
  input  logic [MASTERS-1:0]                  mstHMASTLOCK,
  input  logic [MASTERS-1:0]                  mstHREADY,
  output logic [XLEN-1:0]                     mstHRDATA,
  output logic                                mstHREADYOUT,
  output logic                                mstHRESP,

  output logic                                slv_HSEL,
  output logic [PLEN-1:0]                     slv_HADDR,
  output logic [XLEN-1:0]                     slv_HWDATA,
  output logic                                slv_HWRITE,
  output logic [2:0]                          slv_HSIZE,
  output logic [2:0]                          slv_HBURST,
  output logic [3:0]                          slv_HPROT,
  output logic [1:0]                          slv_HTRANS,
  output logic                                slv_HMASTLOCK,
  output logic                                slv_HREADYOUT,
  input  logic [XLEN-1:0]                     slv_HRDATA,
  input  logic                                slv_HREADY,
  input  logic                                slv_HRESP,

  input  logic [MASTERS-1:0]                  can_switch,
  output logic [MASTERS-1:0]                  granted_master,
  output logic [MASTERS-1:0]                  starved
);

  localparam int LEVELS = 2 ** PRIO_BITS;
  localparam int IDXW   = $clog2(MASTERS);
  localparam int CW     = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0]        LIM = CW'(STARVE_LIMIT);
  localparam logic [PRIO_BITS-1:0] TOP = '1;

  logic [MASTERS-1:0][PRIO_BITS-1:0] eff_prio;
  logic [IDXW-1:0]      grant_idx;
  logic [IDXW-1:0]      addr_idx;
  logic [IDXW-1:0]      data_idx;
  logic [IDXW-1:0]      win_idx;
  logic [IDXW-1:0]      ptr [LEVELS];
  logic [PRIO_BITS-1:0] best;
  logic                 any_req;
  logic                 lock;
  logic                 switch_ok;
  logic                 commit;
  logic                 first_cycle;
  logic [1:0]           htrans_a;
  logic [CW-1:0]        age      [MASTERS];
  logic [CW-1:0]        age_next [MASTERS];
  logic [MASTERS-1:0]   post_grant;
  logic [MASTERS-1:0]   starved_next;

  always_comb begin
    eff_prio = '0;
    for (int m = 0; m < MASTERS; m++)
      eff_prio[m] = starved[m] ? TOP : mstpriority[m];
  end

  // Highest requested level first, then round-robin inside it from that level's pointer.
  always_comb begin
    logic [IDXW-1:0] cand;
    logic            found;
    best    = '0;
    any_req = 1'b0;
    win_idx = grant_idx;
    cand    = '0;
    found   = 1'b0;
    for (int m = 0; m < MASTERS; m++) begin
      if (mstHSEL[m] && (!any_req || eff_prio[m] > best)) begin
        best    = eff_prio[m];
        any_req = 1'b1;
      end
    end
    for (int off = 1; off <= MASTERS; off++) begin
      cand = IDXW'((int'(ptr[best]) + off) % MASTERS);
      if (!found && mstHSEL[cand] && eff_prio[cand] == best) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
  end

  assign lock      = mstHMASTLOCK[grant_idx] & mstHSEL[grant_idx];
  assign switch_ok = slv_HREADY & can_switch[grant_idx] & ~lock;
  assign commit    = switch_ok & any_req;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_idx      <= '0;
      granted_master <= MASTERS'(1);
      addr_idx       <= '0;
      data_idx       <= '0;
      first_cycle    <= 1'b0;
      for (int l = 0; l < LEVELS; l++) ptr[l] <= '0;
    end else if (slv_HREADY) begin
      addr_idx    <= switch_ok ? win_idx : grant_idx;
      data_idx    <= addr_idx;
      first_cycle <= commit && (win_idx != grant_idx);
      if (commit) begin
        grant_idx      <= win_idx;
        granted_master <= MASTERS'(1) << win_idx;
        ptr[best]      <= win_idx;
      end
    end
  end

  // Aging counts a loss against the grant that results from this edge's arbitration.
  always_comb begin
    post_grant   = commit ? (MASTERS'(1) << win_idx) : granted_master;
    starved_next = '0;
    for (int m = 0; m < MASTERS; m++) begin
      age_next[m] = '0;
      if (mstHSEL[m] && !post_grant[m])
        age_next[m] = (age[m] == LIM) ? age[m] : age[m] + CW'(1);
      starved_next[m] = (STARVE_LIMIT > 0) && (age_next[m] == LIM);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      starved <= '0;
      for (int m = 0; m < MASTERS; m++) age[m] <= '0;
    end else if (slv_HREADY) begin
      starved <= starved_next;
      for (int m = 0; m < MASTERS; m++) age[m] <= age_next[m];
    end
  end

  assign htrans_a      = mstHTRANS[addr_idx];
  // A freshly granted master may still be mid-burst; the slave must see a NONSEQ start.
  assign slv_HTRANS    = (first_cycle && htrans_a == 2'b11) ? 2'b10 : htrans_a;
  assign slv_HSEL      = mstHSEL[addr_idx];
  assign slv_HADDR     = mstHADDR[addr_idx];
  assign slv_HWDATA    = mstHWDATA[data_idx];
  assign slv_HWRITE    = mstHWRITE[addr_idx];
  assign slv_HSIZE     = mstHSIZE[addr_idx];
  assign slv_HBURST    = mstHBURST[addr_idx];
  assign slv_HPROT     = mstHPROT[addr_idx];
  assign slv_HMASTLOCK = mstHMASTLOCK[addr_idx];
  assign slv_HREADYOUT = mstHREADY[addr_idx];

  assign mstHRDATA     = slv_HRDATA;
  assign mstHREADYOUT  = slv_HREADY;
  assign mstHRESP      = slv_HRESP;

endmodule

// File: tb/tb_mpsoc_msi_slave_port_qos.sv
// Directed bench for the QoS slave-port arbiter: priority, round-robin, lock,
// aging, SEQ-to-NONSEQ fixup and asynchronous reset, with hand-computed expectations.
module tb_mpsoc_msi_slave_port_qos;
  localparam int PLEN = 32, XLEN = 32, M = 4, PB = 2, SL = 3;

  logic                 HCLK = 1'b0;
  logic                 HRESETn;
  logic [M-1:0][PB-1:0] mstpriority;
  logic [M-1:0]         mstHSEL;
  logic [M-1:0][PLEN-1:0] mstHADDR;
  logic [M-1:0][XLEN-1:0] mstHWDATA;
  logic [M-1:0]         mstHWRITE;
  logic [M-1:0][2:0]    mstHSIZE, mstHBURST;
  logic [M-1:0][3:0]    mstHPROT;
  logic [M-1:0][1:0]    mstHTRANS;
  logic [M-1:0]         mstHMASTLOCK, mstHREADY;
  logic [XLEN-1:0]      mstHRDATA;
  logic                 mstHREADYOUT, mstHRESP;
  logic                 slv_HSEL, slv_HWRITE, slv_HMASTLOCK, slv_HREADYOUT;
  logic [PLEN-1:0]      slv_HADDR;
  logic [XLEN-1:0]      slv_HWDATA, slv_HRDATA;
  logic [2:0]           slv_HSIZE, slv_HBURST;
  logic [3:0]           slv_HPROT;
  logic [1:0]           slv_HTRANS;
  logic                 slv_HREADY, slv_HRESP;
  logic [M-1:0]         can_switch, granted_master, starved;

  int vectors = 0;
  int miscompares = 0;

  mpsoc_msi_slave_port_qos #(.PLEN(PLEN), .XLEN(XLEN), .MASTERS(M), .PRIO_BITS(PB),
                             .STARVE_LIMIT(SL)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .mstpriority(mstpriority), .mstHSEL(mstHSEL),
    .mstHADDR(mstHADDR), .mstHWDATA(mstHWDATA), .mstHWRITE(mstHWRITE),
    .mstHSIZE(mstHSIZE), .mstHBURST(mstHBURST), .mstHPROT(mstHPROT),
    .mstHTRANS(mstHTRANS), .mstHMASTLOCK(mstHMASTLOCK), .mstHREADY(mstHREADY),
    .mstHRDATA(mstHRDATA), .mstHREADYOUT(mstHREADYOUT), .mstHRESP(mstHRESP),
    .slv_HSEL(slv_HSEL), .slv_HADDR(slv_HADDR), .slv_HWDATA(slv_HWDATA),
    .slv_HWRITE(slv_HWRITE), .slv_HSIZE(slv_HSIZE), .slv_HBURST(slv_HBURST),
    .slv_HPROT(slv_HPROT), .slv_HTRANS(slv_HTRANS), .slv_HMASTLOCK(slv_HMASTLOCK),
    .slv_HREADYOUT(slv_HREADYOUT), .slv_HRDATA(slv_HRDATA), .slv_HREADY(slv_HREADY),
    .slv_HRESP(slv_HRESP), .can_switch(can_switch), .granted_master(granted_master),
    .starved(starved)
  );

  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic apply_reset();
    mstpriority  = '0;
    mstHSEL      = '0;
    mstHWRITE    = '0;
    mstHSIZE     = '0;
    mstHBURST    = '0;
    mstHPROT     = '0;
    mstHMASTLOCK = '0;
    mstHREADY    = '1;
    can_switch   = '1;
    slv_HREADY   = 1'b1;
    slv_HRESP    = 1'b0;
    slv_HRDATA   = '0;
    for (int m = 0; m < M; m++) begin
      mstHADDR[m]  = 32'h1000 * (m + 1);
      mstHWDATA[m] = 32'hD000_0000 + m;
      mstHTRANS[m] = 2'b10;
    end
    @(posedge HCLK);
    #1;
    HRESETn = 1'b0;
    #2;
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (granted_master !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_grant actual=%b required=0001", granted_master);
    end
    vectors++;
    if (starved !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_starved actual=%b required=0000", starved);
    end
    vectors++;
    if (slv_HADDR !== 32'h1000) begin
      miscompares++;
      $display("FAIL reset_haddr actual=%h required=00001000", slv_HADDR);
    end
    slv_HRDATA = 32'hCAFE_F00D;
    slv_HREADY = 1'b0;
    slv_HRESP  = 1'b1;
    #1;
    vectors++;
    if ({mstHRDATA, mstHREADYOUT, mstHRESP} !== {32'hCAFE_F00D, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL response_passthru actual=%h/%b/%b required=cafef00d/0/1",
               mstHRDATA, mstHREADYOUT, mstHRESP);
    end
    slv_HREADY = 1'b1;
    slv_HRESP  = 1'b0;
  endtask

  task automatic test_priority();
    apply_reset();
    mstHSEL        = 4'b0110;
    mstpriority[1] = 2'd1;
    mstpriority[2] = 2'd3;
    mstHWRITE      = 4'b0100;
    step();
    vectors++;
    if (granted_master !== 4'b0100) begin
      miscompares++;
      $display("FAIL prio_grant actual=%b required=0100", granted_master);
    end
    vectors++;
    if (slv_HWDATA !== 32'hD000_0000) begin
      miscompares++;
      $display("FAIL prio_wdata_lag actual=%h required=d0000000", slv_HWDATA);
    end
    step();
    vectors++;
    if (slv_HADDR !== 32'h3000 || slv_HWRITE !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_haddr actual=%h/%b required=00003000/1", slv_HADDR, slv_HWRITE);
    end
    vectors++;
    if (slv_HWDATA !== 32'hD000_0002) begin
      miscompares++;
      $display("FAIL prio_wdata actual=%h required=d0000002", slv_HWDATA);
    end
  endtask

  task automatic test_round_robin();
    logic [M-1:0] exp_seq [4];
    exp_seq[0] = 4'b0010;
    exp_seq[1] = 4'b0100;
    exp_seq[2] = 4'b1000;
    exp_seq[3] = 4'b0001;
    apply_reset();
    mstHSEL     = 4'b1111;
    mstpriority = {2'd1, 2'd1, 2'd1, 2'd1};
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (granted_master !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL rr_grant_%0d actual=%b required=%b", i, granted_master, exp_seq[i]);
      end
    end
    can_switch = 4'b1110;
    step();
    vectors++;
    if (granted_master !== 4'b0001) begin
      miscompares++;
      $display("FAIL rr_no_switch_hold actual=%b required=0001", granted_master);
    end
    can_switch = 4'b1111;
  endtask

  task automatic test_lock();
    apply_reset();
    mstHSEL         = 4'b1001;
    mstHMASTLOCK[0] = 1'b1;
    mstpriority[3]  = 2'd3;
    for (int i = 1; i <= 6; i++) begin
      step();
      vectors++;
      if (granted_master !== 4'b0001) begin
        miscompares++;
        $display("FAIL lock_hold_%0d actual=%b required=0001", i, granted_master);
      end
      vectors++;
      if (starved[3] !== (i >= 3)) begin
        miscompares++;
        $display("FAIL lock_starved_%0d actual=%b required=%b", i, starved[3], (i >= 3));
      end
    end
    mstHMASTLOCK[0] = 1'b0;
    step();
    vectors++;
    if (granted_master !== 4'b1000 || starved !== 4'b0000) begin
      miscompares++;
      $display("FAIL lock_release actual=%b/%b required=1000/0000", granted_master, starved);
    end
  endtask

  task automatic test_aging();
    logic [M-1:0] exp_g [4];
    logic [M-1:0] exp_s [4];
    exp_g[0] = 4'b0100; exp_s[0] = 4'b0000;
    exp_g[1] = 4'b1000; exp_s[1] = 4'b0000;
    exp_g[2] = 4'b0100; exp_s[2] = 4'b0010;
    exp_g[3] = 4'b0010; exp_s[3] = 4'b0000;
    apply_reset();
    mstHSEL     = 4'b1110;
    mstpriority = {2'd2, 2'd2, 2'd0, 2'd0};
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (granted_master !== exp_g[i] || starved !== exp_s[i]) begin
        miscompares++;
        $display("FAIL aging_%0d actual=%b/%b required=%b/%b",
                 i, granted_master, starved, exp_g[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_seq_fixup();
    logic [1:0] exp_t [4];
    logic       rdy   [4];
    exp_t[0] = 2'b10; rdy[0] = 1'b1;
    exp_t[1] = 2'b10; rdy[1] = 1'b0;
    exp_t[2] = 2'b10; rdy[2] = 1'b0;
    exp_t[3] = 2'b11; rdy[3] = 1'b1;
    apply_reset();
    mstHSEL      = 4'b0100;
    mstHTRANS[2] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      slv_HREADY = rdy[i];
      step();
      vectors++;
      if (granted_master !== 4'b0100 || slv_HTRANS !== exp_t[i]) begin
        miscompares++;
        $display("FAIL seq_fixup_%0d actual=%b/%b required=0100/%b",
                 i, granted_master, slv_HTRANS, exp_t[i]);
      end
    end
    slv_HREADY = 1'b1;
  endtask

  task automatic test_async_reset();
    apply_reset();
    mstHSEL        = 4'b0101;
    mstpriority[2] = 2'd3;
    repeat (3) step();
    vectors++;
    if (granted_master !== 4'b0100 || starved !== 4'b0001) begin
      miscompares++;
      $display("FAIL areset_pre actual=%b/%b required=0100/0001", granted_master, starved);
    end
    #2;
    HRESETn = 1'b0;
    #1;
    vectors++;
    if (granted_master !== 4'b0001 || starved !== 4'b0000) begin
      miscompares++;
      $display("FAIL areset_now actual=%b/%b required=0001/0000", granted_master, starved);
    end
    #1;
    HRESETn = 1'b1;
  endtask

  initial begin
    HRESETn = 1'b1;
    test_reset();
    test_priority();
    test_round_robin();
    test_lock();
    test_aging();
    test_seq_fixup();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
